// File: rtl/pcie_ib_loader.sv
// Inbound packet loader feeding the Crypto block.
// Takes 128-bit beat packets from the PCIe RX path and hands each packet to a free
// crypto channel, chosen round-robin. The beats go into that channel's buffer window.
// Then the channel's IbPCIeValid is raised. It stays high until Crypto acknowledges on
// IbIPSECValid.
module pcie_ib_loader #(
  parameter int            NUM_CH    = 8,
  parameter int            DW        = 128,
  parameter int            AW        = 32,
  parameter logic [AW-1:0] BUF_BASE  = 32'h0000_0000,
  parameter logic [AW-1:0] CH_STRIDE = 32'h0000_1000,
  parameter int            MAX_BEATS = 256,
  parameter int            LENW      = 9
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DW-1:0]          InData,
  input  logic                   InValid,
  input  logic                   InLast,
  output logic                   InReady,
  output logic                   BufWrEn,
  output logic [AW-1:0]          BufWrAddr,
  output logic [DW-1:0]          BufWrData,
  output logic [NUM_CH-1:0]      IbPCIeValid,
  output logic [NUM_CH*LENW-1:0] IbLen,
  input  logic [NUM_CH-1:0]      IbIPSECValid,
  output logic                   OvfErr
);

  localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } stateT;

  stateT                   stateR, stateS;
  logic [CHW-1:0]          chR, chS;
  logic [CHW-1:0]          rrR;
  logic [LENW-1:0]         cntR;
  logic                    readyR;
  logic                    wrEnR;
  logic [AW-1:0]           wrAddrR;
  logic [DW-1:0]           wrDataR;
  logic                    ovfR;
  logic [NUM_CH-1:0]       validR, validS;
  logic [NUM_CH*LENW-1:0]  lenR;
  logic                    freeFoundS;
  logic [CHW-1:0]          freeChS;
  logic                    acceptS;

  // A beat is taken only while the loader advertises ready, and that happens only in LOAD.
  assign acceptS = InValid & readyR;

  // Round-robin search for the first channel without a pending packet, starting at rrR.
  always_comb begin
    int idx;
    freeFoundS = 1'b0;
    freeChS    = '0;
    idx        = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = int'(rrR) + i;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end else begin
        idx = idx;
      end
      if (!freeFoundS && !validR[idx]) begin
        freeFoundS = 1'b1;
        freeChS    = CHW'(idx);
      end else begin
        freeFoundS = freeFoundS;
      end
    end
  end

  // Next-state logic for the allocate / load / commit sequence.
  always_comb begin
    stateS = stateR;
    chS    = chR;
    case (stateR)
      IDLE: begin
        if (freeFoundS) begin
          stateS = LOAD;
          chS    = freeChS;
        end else begin
          stateS = IDLE;
        end
      end
      LOAD: begin
        if (acceptS && InLast) begin
          stateS = COMMIT;
        end else begin
          stateS = LOAD;
        end
      end
      COMMIT:  stateS = IDLE;
      default: stateS = IDLE;
    endcase
  end

  // Pending-packet flags: an acknowledge clears only a flag that is set; commit sets the loaded channel.
  always_comb begin
    validS = validR & ~IbIPSECValid;
    if (stateR == COMMIT) begin
      validS[chR] = 1'b1;
    end else begin
      validS = validS;
    end
  end

  // State, datapath and channel bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR  <= IDLE;
      chR     <= '0;
      rrR     <= '0;
      cntR    <= '0;
      readyR  <= 1'b0;
      wrEnR   <= 1'b0;
      wrAddrR <= '0;
      wrDataR <= '0;
      ovfR    <= 1'b0;
      validR  <= '0;
      lenR    <= '0;
    end else begin
      stateR <= stateS;
      chR    <= chS;
      readyR <= (stateS == LOAD);
      validR <= validS;
      wrEnR  <= 1'b0;
      ovfR   <= 1'b0;
      if (stateR == IDLE && freeFoundS) begin
        cntR <= '0;
      end else if (acceptS) begin
        if (cntR < LENW'(MAX_BEATS)) begin
          wrEnR   <= 1'b1;
          wrDataR <= InData;
          wrAddrR <= BUF_BASE + (AW'(chR) * CH_STRIDE) + (AW'(cntR) << 4);
          cntR    <= cntR + LENW'(1);
        end else begin
          // The window is full, so the beat is consumed but not written.
          ovfR <= 1'b1;
        end
      end
      if (stateR == COMMIT) begin
        lenR[chR*LENW +: LENW] <= cntR;
        rrR <= (chR == CHW'(NUM_CH - 1)) ? CHW'(0) : chR + CHW'(1);
      end
    end
  end

  assign InReady     = readyR;
  assign BufWrEn     = wrEnR;
  assign BufWrAddr   = wrAddrR;
  assign BufWrData   = wrDataR;
  assign IbPCIeValid = validR;
  assign IbLen       = lenR;
  assign OvfErr      = ovfR;

endmodule

// File: tb/tb_pcie_ib_loader.sv
// Directed self-checking bench for pcie_ib_loader.
module tb_pcie_ib_loader;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] InData;
  logic         InValid;
  logic         InLast;
  logic         InReady;
  logic         BufWrEn;
  logic [31:0]  BufWrAddr;
  logic [127:0] BufWrData;
  logic [7:0]   IbPCIeValid;
  logic [71:0]  IbLen;
  logic [7:0]   IbIPSECValid;
  logic         OvfErr;

  int nChecks = 0;
  int nPass   = 0;

  logic [31:0]  wrAddrQ[$];
  logic [127:0] wrDataQ[$];
  int           ovfCnt = 0;

  pcie_ib_loader dut (
    .clk(clk), .rst_n(rst_n), .InData(InData), .InValid(InValid), .InLast(InLast),
    .InReady(InReady), .BufWrEn(BufWrEn), .BufWrAddr(BufWrAddr), .BufWrData(BufWrData),
    .IbPCIeValid(IbPCIeValid), .IbLen(IbLen), .IbIPSECValid(IbIPSECValid), .OvfErr(OvfErr)
  );

  always #5 clk = ~clk;

  // Record every buffer write and overflow pulse, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && BufWrEn) begin
      wrAddrQ.push_back(BufWrAddr);
      wrDataQ.push_back(BufWrData);
    end
    if (OvfErr) ovfCnt++;
  end

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] beatData(input logic [31:0] tag, input int b);
    return {tag, 64'h0, 32'(b)};
  endfunction

  function automatic logic [8:0] lenOf(input int c);
    return IbLen[c*9 +: 9];
  endfunction

  // Drive one packet starting at a falling edge and return at the falling edge after the last beat is accepted.
  task automatic sendPkt(input int nBeats, input bit gaps, input logic [31:0] tag);
    int   b   = 0;
    int   cyc = 0;
    logic acc;
    while (b < nBeats && cyc < 4000) begin
      InValid = gaps ? ((cyc % 3) != 1) : 1'b1;
      InData  = beatData(tag, b);
      InLast  = (b == nBeats - 1);
      acc     = InValid & InReady;
      @(negedge clk);
      cyc++;
      if (acc) b++;
    end
    InValid = 1'b0;
    InLast  = 1'b0;
    checkVal("pkt_accepted", 128'(b), 128'(nBeats));
  endtask

  task automatic ackPulse(input logic [7:0] mask);
    IbIPSECValid = mask;
    @(negedge clk);
    IbIPSECValid = 8'h00;
  endtask

  initial begin
    int base;
    int ovfBase;
    int readyHigh;
    int w;

    rst_n = 1'b0; InData = '0; InValid = 1'b0; InLast = 1'b0; IbIPSECValid = 8'h00;
    repeat (2) @(negedge clk);
    checkVal("rst_ready", 128'(InReady), 128'(0));
    checkVal("rst_wren", 128'(BufWrEn), 128'(0));
    checkVal("rst_addr", 128'(BufWrAddr), 128'(0));
    checkVal("rst_data", BufWrData, 128'(0));
    checkVal("rst_valid", 128'(IbPCIeValid), 128'(0));
    checkVal("rst_len", 128'(IbLen), 128'(0));
    checkVal("rst_ovf", 128'(OvfErr), 128'(0));
    rst_n = 1'b1;

    // 3-beat packet into ch0, with latency check on write strobe and valid.
    base = wrAddrQ.size();
    sendPkt(3, 1'b0, 32'hA0);
    checkVal("lat_last_wr", 128'(BufWrEn), 128'(1));
    checkVal("lat_valid_early", 128'(IbPCIeValid), 128'(0));
    @(negedge clk);
    checkVal("lat_valid", 128'(IbPCIeValid), 128'(8'h01));
    checkVal("len_ch0", 128'(lenOf(0)), 128'(3));
    @(negedge clk);
    checkVal("p0_count", 128'(wrAddrQ.size() - base), 128'(3));
    for (int i = 0; i < 3; i++) begin
      checkVal("p0_addr", 128'(wrAddrQ[base+i]), 128'(i * 16));
      checkVal("p0_data", wrDataQ[base+i], beatData(32'hA0, i));
    end

    // Fill channels 1..7 in round-robin order.
    for (int ch = 1; ch < 8; ch++) begin
      base = wrAddrQ.size();
      sendPkt(2, 1'b0, 32'(ch));
      repeat (2) @(negedge clk);
      checkVal("fill_count", 128'(wrAddrQ.size() - base), 128'(2));
      checkVal("fill_addr", 128'(wrAddrQ[base]), 128'(ch * 32'h1000));
    end
    checkVal("all_valid", 128'(IbPCIeValid), 128'(8'hFF));

    // No free channel: the loader must stall.
    InValid = 1'b1;
    readyHigh = 0;
    repeat (20) begin
      @(negedge clk);
      if (InReady) readyHigh++;
    end
    InValid = 1'b0;
    checkVal("stall_ready", 128'(readyHigh), 128'(0));

    // Ack ch5; the stalled packet goes there.
    ackPulse(8'h20);
    checkVal("ack5_valid", 128'(IbPCIeValid), 128'(8'hDF));
    base = wrAddrQ.size();
    sendPkt(4, 1'b0, 32'h99);
    repeat (2) @(negedge clk);
    checkVal("ch5_addr", 128'(wrAddrQ[base]), 128'(32'h5000));
    checkVal("ch5_last_addr", 128'(wrAddrQ[base+3]), 128'(32'h5030));
    checkVal("ch5_valid", 128'(IbPCIeValid), 128'(8'hFF));
    checkVal("ch5_len", 128'(lenOf(5)), 128'(4));

    // Reset in the middle of a load.
    ackPulse(8'h01);
    InValid = 1'b1; InLast = 1'b0; InData = beatData(32'hDEAD, 0);
    w = 0;
    while (!BufWrEn && w < 20) begin
      @(negedge clk);
      w++;
    end
    checkVal("midload_wr", 128'(BufWrEn), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    checkVal("midrst_wren", 128'(BufWrEn), 128'(0));
    checkVal("midrst_ready", 128'(InReady), 128'(0));
    checkVal("midrst_valid", 128'(IbPCIeValid), 128'(0));
    checkVal("midrst_len", 128'(IbLen), 128'(0));
    checkVal("midrst_addr", 128'(BufWrAddr), 128'(0));
    InValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Round-robin continues past an acked lower channel; ignored and multiple acks.
    base = wrAddrQ.size();
    sendPkt(1, 1'b0, 32'hB0);
    sendPkt(1, 1'b0, 32'hB1);
    sendPkt(1, 1'b0, 32'hB2);
    repeat (2) @(negedge clk);
    checkVal("restart_addr", 128'(wrAddrQ[base]), 128'(0));
    checkVal("rr_valid3", 128'(IbPCIeValid), 128'(8'h07));
    ackPulse(8'h82);
    checkVal("ack1_ign7", 128'(IbPCIeValid), 128'(8'h05));
    base = wrAddrQ.size();
    sendPkt(1, 1'b0, 32'hB3);
    repeat (2) @(negedge clk);
    checkVal("rr_ch3_addr", 128'(wrAddrQ[base]), 128'(32'h3000));
    checkVal("rr_valid", 128'(IbPCIeValid), 128'(8'h0D));
    ackPulse(8'h09);
    checkVal("multi_ack", 128'(IbPCIeValid), 128'(8'h04));

    // Overflow: 260-beat packet after a fresh reset.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base = wrAddrQ.size();
    ovfBase = ovfCnt;
    sendPkt(260, 1'b0, 32'hC0);
    repeat (3) @(negedge clk);
    checkVal("ovf_writes", 128'(wrAddrQ.size() - base), 128'(256));
    checkVal("ovf_last_addr", 128'(wrAddrQ[wrAddrQ.size()-1]), 128'(32'h0FF0));
    checkVal("ovf_last_data", wrDataQ[wrDataQ.size()-1], beatData(32'hC0, 255));
    checkVal("ovf_pulses", 128'(ovfCnt - ovfBase), 128'(4));
    checkVal("ovf_len", 128'(lenOf(0)), 128'(256));
    checkVal("ovf_valid", 128'(IbPCIeValid), 128'(8'h01));

    // 5-beat packet with InValid gaps into ch1.
    base = wrAddrQ.size();
    sendPkt(5, 1'b1, 32'hD0);
    repeat (3) @(negedge clk);
    checkVal("gap_count", 128'(wrAddrQ.size() - base), 128'(5));
    for (int i = 0; i < 5; i++) begin
      checkVal("gap_addr", 128'(wrAddrQ[base+i]), 128'(32'h1000 + i * 16));
      checkVal("gap_data", wrDataQ[base+i], beatData(32'hD0, i));
    end
    checkVal("gap_len", 128'(lenOf(1)), 128'(5));
    checkVal("gap_valid", 128'(IbPCIeValid), 128'(8'h03));

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
